// File: rtl/ps2_command_sender.sv
`default_nettype none
// ============================================================================
// Module   : ps2_command_sender
// Purpose  : Host-to-device side of a PS2 link. Sends one command byte over
//            the open-drain PS2_CLK / PS2_DAT lines. It then checks for the
//            device acknowledge and reports success, no-ack or timeout.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK_50                   in   system clock (50 MHz)
//   resetn                     in   synchronous reset, active-high
//   commandToSend[7:0]         in   command byte, latched on accept
//   sendCommand                in   request strobe, accepted only when idle
//   ps2_clk_in / ps2_dat_in    in   raw line levels (asynchronous)
//   ps2_clk_drive_low          out  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_drive_low          out  1 = pull PS2_DAT low, 0 = release
//   busy                       out  accept .. result pulse, inclusive
//   commandWasSent             out  1-cycle pulse, acked and lines idle
//   errorCommunicationTimedOut out  1-cycle pulse, start/transfer timeout
//   errorNoAck                 out  1-cycle pulse, ack bit sampled high
// ============================================================================
module ps2_command_sender #(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_HOLD_CYCLES    = 20,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000,
  parameter int CNT_W                = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] commandToSend,
  input  logic       sendCommand,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       commandWasSent,
  output logic       errorCommunicationTimedOut,
  output logic       errorNoAck
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST    = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_TO_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_TO_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INHIBIT    = 4'd1,
    START      = 4'd2,
    WAIT_FIRST = 4'd3,
    SEND       = 4'd4,
    WAIT_ACK   = 4'd5,
    WAIT_IDLE  = 4'd6,
    DONE       = 4'd7,
    ERR_TO     = 4'd8,
    ERR_NOACK  = 4'd9
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [3:0]       bit_idx;
  logic [7:0]       data;
  logic             parity;

  // Two-flop synchronisers. clk_prev is one stage further down the chain and
  // holds the previous synced CLK level, which the edge detector needs.
  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;

  // Reset the synchronisers to the idle-high line level. This stops a
  // false fall from being seen straight out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  logic             fall;
  logic             start_expired;
  logic             xfer_expired;
  logic [CNT_W-1:0] timer_inc;

  assign fall          = clk_prev & ~clk_sync;
  assign start_expired = (timer >= START_TO_LAST);
  assign xfer_expired  = (timer >= XFER_TO_LAST);
  // The timer saturates rather than wrapping, so an expiry cannot be missed.
  assign timer_inc     = (timer == {CNT_W{1'b1}}) ? timer : timer + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      state                      <= IDLE;
      timer                      <= '0;
      bit_idx                    <= '0;
      data                       <= '0;
      parity                     <= 1'b0;
      ps2_clk_drive_low          <= 1'b0;
      ps2_dat_drive_low          <= 1'b0;
      busy                       <= 1'b0;
      commandWasSent             <= 1'b0;
      errorCommunicationTimedOut <= 1'b0;
      errorNoAck                 <= 1'b0;
    end else begin
      // Result outputs are single-cycle pulses unless a state re-asserts them.
      commandWasSent             <= 1'b0;
      errorCommunicationTimedOut <= 1'b0;
      errorNoAck                 <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          if (sendCommand) begin
            data              <= commandToSend;
            parity            <= ~^commandToSend;
            timer             <= '0;
            bit_idx           <= '0;
            busy              <= 1'b1;
            ps2_clk_drive_low <= 1'b1;
            state             <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (timer >= INHIBIT_LAST) begin
            timer             <= '0;
            ps2_dat_drive_low <= 1'b1;
            state             <= START;
          end else begin
            timer <= timer_inc;
          end
        end

        START: begin
          // Releasing CLK while DAT stays low is the request-to-send
          // condition. The low DAT level is the start bit.
          if (timer >= START_LAST) begin
            timer             <= '0;
            ps2_clk_drive_low <= 1'b0;
            state             <= WAIT_FIRST;
          end else begin
            timer <= timer_inc;
          end
        end

        WAIT_FIRST: begin
          // The expiry check comes first so that a timeout wins over a
          // fall that arrives in the same cycle.
          if (start_expired) begin
            ps2_dat_drive_low          <= 1'b0;
            errorCommunicationTimedOut <= 1'b1;
            state                      <= ERR_TO;
          end else if (fall) begin
            ps2_dat_drive_low <= ~data[0];
            bit_idx           <= 4'd1;
            timer             <= '0;
            state             <= SEND;
          end else begin
            timer <= timer_inc;
          end
        end

        SEND, WAIT_ACK, WAIT_IDLE: begin
          // One transfer budget covers the span from the first fall to
          // the point where the lines go idle.
          if (xfer_expired) begin
            ps2_clk_drive_low          <= 1'b0;
            ps2_dat_drive_low          <= 1'b0;
            errorCommunicationTimedOut <= 1'b1;
            state                      <= ERR_TO;
          end else begin
            timer <= timer_inc;
            case (state)
              SEND: begin
                if (fall) begin
                  bit_idx <= bit_idx + 4'd1;
                  if (bit_idx == 4'd9) begin
                    ps2_dat_drive_low <= 1'b0;     // stop bit: line released
                    state             <= WAIT_ACK;
                  end else if (bit_idx == 4'd8) begin
                    ps2_dat_drive_low <= ~parity;
                  end else begin
                    ps2_dat_drive_low <= ~data[bit_idx[2:0]];
                  end
                end
              end
              WAIT_ACK: begin
                if (fall) begin
                  if (!dat_sync) begin
                    state <= WAIT_IDLE;
                  end else begin
                    errorNoAck <= 1'b1;
                    state      <= ERR_NOACK;
                  end
                end
              end
              WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                  commandWasSent <= 1'b1;
                  state          <= DONE;
                end
              end
              default: ;
            endcase
          end
        end

        // The pulse is on the outputs during this cycle. busy drops after it.
        DONE, ERR_TO, ERR_NOACK: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          state             <= IDLE;
        end

        default: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_command_sender
// Purpose  : Self-checking bench for ps2_command_sender. It uses a behavioural
//            PS2 device that clocks at a 40-cycle period.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_command_sender;

  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] commandToSend = 8'h00;
  logic       sendCommand = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_drive_low, ps2_dat_drive_low;
  logic       busy, commandWasSent, errorCommunicationTimedOut, errorNoAck;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  // Open-drain wired-AND of the host and device drivers.
  assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_command_sender #(
    .INHIBIT_CYCLES      (10),
    .START_HOLD_CYCLES   (4),
    .START_TIMEOUT_CYCLES(200),
    .XFER_TIMEOUT_CYCLES (2000),
    .CNT_W               (20)
  ) dut (
    .CLOCK_50                  (CLOCK_50),
    .resetn                    (resetn),
    .commandToSend             (commandToSend),
    .sendCommand               (sendCommand),
    .ps2_clk_in                (ps2_clk_in),
    .ps2_dat_in                (ps2_dat_in),
    .ps2_clk_drive_low         (ps2_clk_drive_low),
    .ps2_dat_drive_low         (ps2_dat_drive_low),
    .busy                      (busy),
    .commandWasSent            (commandWasSent),
    .errorCommunicationTimedOut(errorCommunicationTimedOut),
    .errorNoAck                (errorNoAck)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Free-running monitor of the DUT outputs, sampled on the falling clock edge.
  int cyc = 0, clk_low_cnt = 0, n_done = 0, n_noack = 0, n_to = 0;
  int n_coinc = 0, n_busy = 0, rel = 0, to_lat = -1, to_cyc = 0;
  logic prev_cdl = 1'b0;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (ps2_clk_drive_low) clk_low_cnt++;
    if (busy) n_busy++;
    if (commandWasSent) n_done++;
    if (errorNoAck) n_noack++;
    if (errorCommunicationTimedOut) n_to++;
    if (int'(commandWasSent) + int'(errorNoAck) + int'(errorCommunicationTimedOut) > 1) n_coinc++;
    if (prev_cdl && !ps2_clk_drive_low) rel = 0;
    else rel++;
    if (errorCommunicationTimedOut) begin
      to_lat = rel;
      to_cyc = cyc;
    end
    prev_cdl = ps2_clk_drive_low;
  end

  // Device model: waits for the start condition, then clocks out nfalls falls.
  // It samples DAT at the end of each low phase and drives the ack at fall 11.
  logic [9:0] dev_samp;
  int         dev_falls = 0;
  int         first_fall_cyc = 0;
  bit         dev_ok;

  task automatic device(input int nfalls, input bit ack, output bit ok);
    int w;
    ok = 1'b1;
    if (nfalls == 0) return;
    w = 0;
    while (!(ps2_clk_drive_low == 1'b0 && ps2_dat_drive_low == 1'b1) && w < 300) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (w >= 300) begin
      ok = 1'b0;
      return;
    end
    repeat (10) @(negedge CLOCK_50);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11) begin
        dev_dat_low = ack;
        repeat (5) @(negedge CLOCK_50);
      end
      dev_clk_low = 1'b1;
      if (k == 1) first_fall_cyc = cyc;
      dev_falls = k;
      repeat (HALF) @(negedge CLOCK_50);
      if (k <= 10) dev_samp[k-1] = ps2_dat_in;
      dev_clk_low = 1'b0;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
    end
  endtask

  task automatic wait_pulse();
    int w = 0;
    while (!(commandWasSent | errorNoAck | errorCommunicationTimedOut) && w < 6000) begin
      @(negedge CLOCK_50);
      w++;
    end
    check("pulse_wait_in_budget", int'(w < 6000), 1);
    @(negedge CLOCK_50);
  endtask

  task automatic request(input logic [7:0] cmd);
    @(negedge CLOCK_50);
    commandToSend = cmd;
    sendCommand   = 1'b1;
    @(negedge CLOCK_50);
    sendCommand   = 1'b0;
    commandToSend = ~cmd;   // a change after accept must not affect the frame
  endtask

  // lat_kind: 0 = no latency check, 1 = start timeout (exact),
  // 2 = transfer timeout measured from the first device fall.
  typedef struct {
    logic [7:0] cmd;
    int         nfalls;
    bit         ack;
    logic [9:0] bits;   // {stop, parity, d7..d0} as seen by the device
    int         exp_done;
    int         exp_noack;
    int         exp_to;
    int         lat_kind;
  } vec_t;

  vec_t vecs[6];

  int s_done, s_noack, s_to, s_clk, s_coinc, s_busy;

  task automatic snap();
    s_done  = n_done;
    s_noack = n_noack;
    s_to    = n_to;
    s_clk   = clk_low_cnt;
    s_coinc = n_coinc;
    s_busy  = n_busy;
  endtask

  initial begin
    vecs[0] = '{8'hED, 11, 1'b1, 10'h3ED, 1, 0, 0, 0};
    vecs[1] = '{8'hF4, 11, 1'b1, 10'h2F4, 1, 0, 0, 0};
    vecs[2] = '{8'h3C,  0, 1'b1, 10'h000, 0, 0, 1, 1};
    vecs[3] = '{8'h55, 11, 1'b0, 10'h355, 0, 1, 0, 0};
    vecs[4] = '{8'h81,  5, 1'b1, 10'h000, 0, 0, 1, 2};
    vecs[5] = '{8'hFF, 11, 1'b1, 10'h3FF, 1, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_clk_drive", int'(ps2_clk_drive_low), 0);
    check("rst_dat_drive", int'(ps2_dat_drive_low), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'(commandWasSent) + int'(errorNoAck) + int'(errorCommunicationTimedOut), 0);
    resetn = 1'b0;
    repeat (5) @(negedge CLOCK_50);

    for (int i = 0; i < 6; i++) begin
      snap();
      dev_samp  = '0;
      dev_falls = 0;
      request(vecs[i].cmd);
      fork
        device(vecs[i].nfalls, vecs[i].ack, dev_ok);
        wait_pulse();
      join
      if (vecs[i].nfalls > 0) check($sformatf("v%0d_start_cond", i), int'(dev_ok), 1);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
      check($sformatf("v%0d_drives_released", i), int'(ps2_clk_drive_low | ps2_dat_drive_low), 0);
      check($sformatf("v%0d_done_cnt", i), n_done - s_done, vecs[i].exp_done);
      check($sformatf("v%0d_noack_cnt", i), n_noack - s_noack, vecs[i].exp_noack);
      check($sformatf("v%0d_timeout_cnt", i), n_to - s_to, vecs[i].exp_to);
      check($sformatf("v%0d_clk_low_cycles", i), clk_low_cnt - s_clk, 14);
      check($sformatf("v%0d_coincident", i), n_coinc - s_coinc, 0);
      if (vecs[i].nfalls >= 10) check($sformatf("v%0d_bits", i), int'(dev_samp), int'(vecs[i].bits));
      if (vecs[i].lat_kind == 1) check($sformatf("v%0d_start_to_latency", i), to_lat, 200);
      if (vecs[i].lat_kind == 2) check_range($sformatf("v%0d_xfer_to_latency", i), to_cyc - first_fall_cyc, 2000, 2006);
      repeat (10) @(negedge CLOCK_50);
    end

    // Reset asserted during bit 4, with a request coincident with the reset
    snap();
    dev_falls = 0;
    request(8'hED);
    fork
      device(11, 1'b1, dev_ok);
      begin
        int w = 0;
        while (dev_falls < 5 && w < 2000) begin
          @(negedge CLOCK_50);
          w++;
        end
        check("rst_mid_reached_bit4", int'(w < 2000), 1);
        repeat (8) @(negedge CLOCK_50);
        resetn        = 1'b1;
        sendCommand   = 1'b1;
        commandToSend = 8'h12;
        @(negedge CLOCK_50);
        check("rst_mid_clk_drive", int'(ps2_clk_drive_low), 0);
        check("rst_mid_dat_drive", int'(ps2_dat_drive_low), 0);
        check("rst_mid_busy", int'(busy), 0);
        resetn      = 1'b0;
        sendCommand = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        check("rst_coincident_req_ignored", int'(busy), 0);
      end
    join
    check("rst_mid_no_pulses", (n_done - s_done) + (n_noack - s_noack) + (n_to - s_to), 0);
    repeat (10) @(negedge CLOCK_50);

    // A second request while busy is dropped, not queued
    snap();
    dev_samp  = '0;
    dev_falls = 0;
    request(8'hF4);
    fork
      device(11, 1'b1, dev_ok);
      wait_pulse();
      begin
        repeat (60) @(negedge CLOCK_50);
        commandToSend = 8'h00;
        sendCommand   = 1'b1;
        @(negedge CLOCK_50);
        sendCommand   = 1'b0;
      end
    join
    check("busy_req_done_cnt", n_done - s_done, 1);
    check("busy_req_bits", int'(dev_samp), int'(10'h2F4));
    s_busy = n_busy;
    repeat (100) @(negedge CLOCK_50);
    check("busy_req_not_queued", n_busy - s_busy, 0);
    check("busy_req_total_pulses", (n_done - s_done) + (n_noack - s_noack) + (n_to - s_to), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ps2_command_sender.md
Name: ps2_command_sender

Overview:
- Host-to-device half of the PS2 link: serialises one 8-bit command (e.g. 8'hED set-LEDs, 8'hF4 enable, 8'hFF reset) onto the open-drain PS2_CLK/PS2_DAT lines, checks for the device acknowledge, and reports success or timeout.
- Complements the scan-code receive path; top level maps the drive-low outputs onto the PS2_CLK/PS2_DAT inouts.

Parameters:
- INHIBIT_CYCLES, 6000, CLOCK_50 cycles the host holds CLK low before start (120 us).
- START_HOLD_CYCLES, 20, cycles DAT is held low with CLK still low before CLK is released.
- START_TIMEOUT_CYCLES, 750000, maximum wait from CLK release to the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000, maximum wait from the first falling edge to ack plus line idle (2 ms).
- CNT_W, 20, timer width; must hold the largest cycle parameter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous reset, active-high (asserted = reset), sampled on posedge CLOCK_50.
- commandToSend  in  8  command byte; sampled only on an accepted request.
- sendCommand  in  1  request strobe; accepted only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK line level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT line level (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull PS2_CLK low, 0 = release (high-Z).
- ps2_dat_drive_low  out  1  1 = pull PS2_DAT low, 0 = release.
- busy  out  1  high from accept until the done/error pulse cycle inclusive.
- commandWasSent  out  1  one-cycle pulse: device acknowledged and both lines returned high.
- errorCommunicationTimedOut  out  1  one-cycle pulse: a start or transfer timeout occurred.
- errorNoAck  out  1  one-cycle pulse: ack bit sampled high.

Behaviour:
- Input synchronisation: two-flop synchronisers on ps2_clk_in and ps2_dat_in.
  - fall = previous synced CLK high AND current synced CLK low.
  - Every line decision uses synced values only.
- Reset, any time including mid-transfer:
  - State returns to IDLE; timers and bit count clear.
  - All outputs are 0 on the cycle after reset is sampled, so both lines are released immediately.
- FSM:
  - IDLE: lines released. On sendCommand=1, latch the byte, compute odd parity (parity = ~^byte), clear the timer, set busy, go to INHIBIT.
  - INHIBIT: clk_drive_low=1 for INHIBIT_CYCLES cycles, then go to START.
  - START: clk_drive_low=1 and dat_drive_low=1 for START_HOLD_CYCLES cycles. Then release CLK with DAT still low (start bit) and go to WAIT_FIRST.
  - WAIT_FIRST: on fall, drive d0 (dat_drive_low = ~d0) in the same transition, set bitIdx=1, and go to SEND with the transfer timer cleared. If START_TIMEOUT_CYCLES elapse with no fall, go to ERR_TO.
  - SEND: on each fall, advance:
    - bitIdx 1..7 drives d1..d7;
    - bitIdx 8 drives parity;
    - bitIdx 9 releases DAT (stop bit), then go to WAIT_ACK.
    - Data changes only on fall edges.
  - WAIT_ACK: on fall (11th), sample synced DAT. If low, go to WAIT_IDLE; if high, go to ERR_NOACK.
  - WAIT_IDLE: wait until synced CLK and DAT are both high, then go to DONE.
  - DONE: commandWasSent=1 for one cycle, then IDLE.
  - ERR_TO: errorCommunicationTimedOut=1 for one cycle, lines released, then IDLE.
  - ERR_NOACK: errorNoAck=1 for one cycle, lines released, then IDLE.
- Transfer timeout: in SEND, WAIT_ACK and WAIT_IDLE, exceeding XFER_TIMEOUT_CYCLES since the first fall goes to ERR_TO. The timer counts up and saturates; no wrap.
- Request handling:
  - sendCommand while busy is ignored, with no queueing.
  - sendCommand coincident with reset is ignored.
  - commandToSend changes after accept have no effect.
- Simultaneous events: if a timeout expiry and a fall occur in the same cycle, the timeout wins.
- Glitch rejection: a rising edge with no preceding fall is not counted.
- Exclusivity: done and error pulses never coincide, and exactly one fires per accepted request.
- Busy de-asserts the cycle after the pulse; a new request is accepted the cycle after that.

Test Plan:
- Bench uses INHIBIT=10, START_HOLD=4, START_TIMEOUT=200, XFER_TIMEOUT=2000, and a device model clocking at 40-cycle period.
- Send 8'hED with the device model acking:
  - DAT at the 1st..9th fall releases = 1,0,1,1,0,1,1,1, parity 1; stop released.
  - commandWasSent pulses once, busy drops.
- Send 8'hF4:
  - Bits 0,0,1,0,1,1,1,1, parity 0.
  - CLK held low exactly 10+4 cycles before release.
  - commandWasSent pulses once.
- Device never clocks: errorCommunicationTimedOut pulses 200 cycles after CLK release; both drive outputs 0; commandWasSent stays 0.
- Device holds DAT high at the 11th fall: errorNoAck pulses once, no commandWasSent.
- Device stops after 5 falls: errorCommunicationTimedOut at the transfer timeout; FSM idle; the next 8'hFF send succeeds.
- Assert resetn during bit 4:
  - Next cycle both drive outputs 0, busy 0, no pulses.
  - sendCommand during busy of a later send is ignored; only one completion pulse occurs.
